// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings and the
// load-use stall FSM state type.
package pipe_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WR  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard/forwarding
// controller (slave).
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int PERF_W     = 16
);

    logic [NUM_SRC*REG_ADDR_W-1:0] src_ID;
    logic [NUM_SRC-1:0]            src_used_ID;
    logic [REG_ADDR_W-1:0]         rw_EX;
    logic [REG_ADDR_W-1:0]         rw_MEM;
    logic                          RegWr_EX;
    logic                          RegWr_MEM;
    logic                          MemRead_EX;
    logic                          MemRead_MEM;
    logic                          flush_ID;
    logic                          mem_busy;
    logic [NUM_SRC*2-1:0]          fwd_sel_EX;
    logic                          stall_IF;
    logic                          bubble_EX;
    logic [PERF_W-1:0]             stall_cnt;

    modport master (
        output src_ID, src_used_ID, rw_EX, rw_MEM, RegWr_EX, RegWr_MEM,
               MemRead_EX, MemRead_MEM, flush_ID, mem_busy,
        input  fwd_sel_EX, stall_IF, bubble_EX, stall_cnt
    );

    modport slave (
        input  src_ID, src_used_ID, rw_EX, rw_MEM, RegWr_EX, RegWr_MEM,
               MemRead_EX, MemRead_MEM, flush_ID, mem_busy,
        output fwd_sel_EX, stall_IF, bubble_EX, stall_cnt
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand bypass priority: an ALU result in EX beats anything in MEM;
// a load still in EX cannot be forwarded and is flagged as a load-use hit.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    input  logic [REG_ADDR_W-1:0] rw_EX,
    input  logic                  RegWr_EX,
    input  logic                  MemRead_EX,
    input  logic [REG_ADDR_W-1:0] rw_MEM,
    input  logic                  RegWr_MEM,
    output logic [1:0]            sel,
    output logic                  load_hit
);

    logic match_ex;
    logic match_mem;

    assign match_ex  = used && (src != '0) && RegWr_EX  && (rw_EX  == src);
    assign match_mem = used && (src != '0) && RegWr_MEM && (rw_MEM == src);
    assign load_hit  = match_ex && MemRead_EX;

    always_comb begin
        sel = FWD_RF;
        if (match_ex && !MemRead_EX) begin
            sel = FWD_MEM;
        end else if (match_mem) begin
            sel = FWD_WR;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection with programmable bubble count, registered
// per-operand bypass selects and a saturating stall-cycle counter.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_SRC    = 2,
    parameter int LU_CYCLES  = 1,
    parameter int PERF_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    hazard_forward_unit_if.slave bus
);

    localparam int CNT_W = (LU_CYCLES > 1) ? $clog2(LU_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LU_CYCLES - 1);

    fsm_state_t              state;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_SRC-1:0]      load_hit;
    logic [NUM_SRC*2-1:0]    next_sel;
    logic [NUM_SRC*2-1:0]    fwd_sel_q;
    logic [PERF_W-1:0]       stall_cnt_q;
    logic                    hazard;
    logic                    stall_now;
    logic                    bubble_now;
    logic                    count_now;
    logic                    unused_mem_read;

    // MEM-stage results are forwarded whether or not they came from a load.
    assign unused_mem_read = bus.MemRead_MEM;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_select #(
                .REG_ADDR_W(REG_ADDR_W)
            ) u_sel (
                .src       (bus.src_ID[g*REG_ADDR_W +: REG_ADDR_W]),
                .used      (bus.src_used_ID[g]),
                .rw_EX     (bus.rw_EX),
                .RegWr_EX  (bus.RegWr_EX),
                .MemRead_EX(bus.MemRead_EX),
                .rw_MEM    (bus.rw_MEM),
                .RegWr_MEM (bus.RegWr_MEM),
                .sel       (next_sel[g*2 +: 2]),
                .load_hit  (load_hit[g])
            );
        end
    endgenerate

    assign hazard = |load_hit;

    // Freeze silences both Mealy outputs; a flush bubbles EX but releases IF.
    always_comb begin
        stall_now  = 1'b0;
        bubble_now = 1'b0;
        count_now  = 1'b0;
        if (!rst && !bus.mem_busy) begin
            if (bus.flush_ID) begin
                bubble_now = 1'b1;
            end else if ((state == ST_STALL) || hazard) begin
                stall_now  = 1'b1;
                bubble_now = 1'b1;
                count_now  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else if (!bus.mem_busy) begin
            if (bus.flush_ID) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (state == ST_STALL) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state <= ST_IDLE;
                end
            end else if (hazard && (LU_CYCLES > 1)) begin
                state <= ST_STALL;
                cnt   <= CNT_INIT;
            end

            fwd_sel_q <= bubble_now ? '0 : next_sel;

            if (count_now && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_IF   = stall_now;
    assign bus.bubble_EX  = bubble_now;
    assign bus.fwd_sel_EX = fwd_sel_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule
